mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL: clk  input  1  clock; all state updates on posedge clk.
REQ-002 SHALL: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL: es_to_ms_bus  input  103  request, packed MSB..LSB {addr[31:0], is_unsigned, mem_we, mem_re, bit_width[3:0], wdata[31:0], pc[31:0]}; mem_we/mem_re already qualified by valid and exception.
REQ-004 SHALL: ms_to_es_bus  output  34  response, packed MSB..LSB {excp_ale, dcache_ok, mem_result[31:0]}.
REQ-005 SHALL: data_sram_req  output  1  memory request valid.
REQ-006 SHALL: data_sram_wr  output  1  1 = store, 0 = load.
REQ-007 SHALL: data_sram_wstrb  output  4  byte write strobes; 0 for loads.
REQ-008 SHALL: data_sram_addr  output  32  byte address.
REQ-009 SHALL: data_sram_wdata  output  32  lane-replicated store data.
REQ-010 SHALL: data_sram_addr_ok  input  1  request accepted this cycle.
REQ-011 SHALL: data_sram_data_ok  input  1  load data / store completion this cycle.
REQ-012 SHALL: data_sram_rdata  input  32  load data, valid with data_ok.

Function
REQ-013 SHALL: bit_width encoding 4'b0001 byte, 4'b0011 half, 4'b1111 word; any other value is treated as word.
REQ-014 SHALL: FSM states IDLE, REQ, WAIT, DONE.
REQ-015 SHALL: No access (mem_we=mem_re=0) means dcache_ok=1, excp_ale=0, mem_result=0 combinationally, no memory request, and the FSM stays in IDLE.
REQ-016 SHALL: In IDLE with an aligned access, drive data_sram_req=1 combinationally. On addr_ok go to WAIT, otherwise go to REQ.
REQ-017 SHALL: In REQ, hold data_sram_req=1 with unchanged addr, wr, wstrb and wdata until addr_ok, then go to WAIT.
REQ-018 SHALL: In WAIT, data_sram_req=0. On data_ok, capture the formatted load result (0 for stores), latch {pc, addr, we, re}, and go to DONE.
REQ-019 SHALL: In DONE, dcache_ok=1 and mem_result=captured value, with no new request. Stay in DONE while the bus {pc, addr, we, re} equals the latched copy. Otherwise re-evaluate as IDLE in the same cycle, so a new access can be issued immediately.
REQ-020 SHALL: In IDLE, REQ and WAIT, dcache_ok=0 for any access that issues a memory request. Minimum latency: req+addr_ok in cycle 0, data_ok in cycle 1, dcache_ok in cycle 2.
REQ-021 SHALL: Store strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-022 SHALL: Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-023 SHALL: Load result: shift rdata right by addr[1:0]*8, then sign- or zero-extend from bit 7 (byte) or bit 15 (half) per is_unsigned; word loads pass through unchanged.
REQ-024 SHALL: A data_ok arriving in IDLE, REQ or DONE is ignored.
REQ-025 SHALL: The request bus is held stable by the producer while dcache_ok=0; no abort path exists.

Reset
REQ-026 SHALL: Reset forces the FSM to IDLE and clears the captured result and latched request to 0.
REQ-027 SHALL: data_sram_req=0 while reset is high. Reset mid-access abandons the access; the memory side shares the same reset, so no stale data_ok follows.

Configuration
REQ-028 SHALL: Macro DMEM_ALE_CHECK_EN, when defined, enables alignment checking. A half access with addr[0]=1 or a word access with addr[1:0]!=0 issues no request and returns excp_ale=1, dcache_ok=1, mem_result=0 combinationally, with the FSM in IDLE.
REQ-029 SHALL: When DMEM_ALE_CHECK_EN is undefined, excp_ale is constant 0. Misaligned accesses are issued with data_sram_addr low bits cleared to natural alignment, and strobes and extraction use the cleared address.

Verification
REQ-030 SHALL: Byte load, addr=0x1003, is_unsigned=0, addr_ok at cycle 0, data_ok at cycle 1 with rdata=0x80AABBCC -> addr=0x1003, wstrb=0, mem_result=0xFFFFFF80, dcache_ok=1 at cycle 2.
REQ-031 SHALL: Half store, addr=0x2002, wdata=0x1234ABCD -> wr=1, wstrb=4'b1100, sram wdata=0xABCDABCD; dcache_ok=1 one cycle after data_ok.
REQ-032 SHALL: Word load with addr_ok withheld for 3 cycles -> req held high with a stable addr for 4 cycles, then WAIT, then completion; dcache_ok=0 throughout.
REQ-033 SHALL: Request held in DONE for 2 extra cycles, then the bus switches to a new load -> dcache_ok stays 1 with no duplicate req; the new req appears in the switch cycle.
REQ-034 SHALL: With DMEM_ALE_CHECK_EN, word load at addr=0x3001 -> excp_ale=1, dcache_ok=1, data_sram_req=0. Without the macro -> req issued with addr=0x3000, excp_ale=0.
REQ-035 SHALL: Reset asserted in WAIT -> FSM in IDLE, req=0 next cycle; a following no-access cycle gives dcache_ok=1 and mem_result=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory access stage between execute and the data SRAM
// port. Formats store strobes/data and load results, and runs a small
// request/response handshake FSM (IDLE, REQ, WAIT, DONE).
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   es_to_ms_bus[102:0] {addr, is_unsigned, mem_we, mem_re, bit_width, wdata, pc}
//   ms_to_es_bus[33:0]  {excp_ale, dcache_ok, mem_result}
//   data_sram_*         request side (req/wr/wstrb/addr/wdata) and response
//                       side (addr_ok/data_ok/rdata) of the memory port
//
// Optional feature: define DMEM_ALE_CHECK_EN to trap misaligned half/word
// accesses with excp_ale instead of issuing them. Without it, misaligned
// accesses are issued with the low address bits cleared to natural alignment.
//
// Latency: best case request+addr_ok in cycle 0, data_ok in cycle 1,
// dcache_ok in cycle 2. The producer holds the request bus stable while
// dcache_ok is low.

module mem_access_unit (
  input  logic         clk,
  input  logic         reset,
  input  logic [102:0] es_to_ms_bus,
  output logic [33:0]  ms_to_es_bus,
  output logic         data_sram_req,
  output logic         data_sram_wr,
  output logic [3:0]   data_sram_wstrb,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  input  logic         data_sram_addr_ok,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // Request bus fields
  logic [31:0] req_addr;
  logic        is_unsigned;
  logic        mem_we;
  logic        mem_re;
  logic [3:0]  bit_width;
  logic [31:0] st_wdata;
  logic [31:0] req_pc;

  assign {req_addr, is_unsigned, mem_we, mem_re, bit_width, st_wdata, req_pc} = es_to_ms_bus;

  // Access size decode; any unknown encoding behaves as a word access
  logic is_byte, is_half, is_word, access;
  assign is_byte = (bit_width == 4'b0001);
  assign is_half = (bit_width == 4'b0011);
  assign is_word = !is_byte && !is_half;
  assign access  = mem_we || mem_re;

  logic ale;
`ifdef DMEM_ALE_CHECK_EN
  logic misaligned;
  assign misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
  assign ale        = access && misaligned;
`else
  assign ale        = 1'b0;
`endif

  // Naturally aligned address: with the check enabled only aligned accesses
  // reach the memory, so clearing the low bits is harmless there too.
  logic [31:0] aligned_addr;
  logic [1:0]  off;
  assign aligned_addr = is_word ? {req_addr[31:2], 2'b00} :
                        is_half ? {req_addr[31:1], 1'b0}  : req_addr;
  assign off = aligned_addr[1:0];

  // Store formatting
  logic [3:0]  strb;
  logic [31:0] wdata_rep;
  always_comb begin
    strb      = 4'b0000;
    wdata_rep = st_wdata;
    if (is_byte) begin
      strb      = 4'b0001 << off;
      wdata_rep = {4{st_wdata[7:0]}};
    end else if (is_half) begin
      strb      = 4'b0011 << {off[1], 1'b0};
      wdata_rep = {2{st_wdata[15:0]}};
    end else begin
      strb      = 4'b1111;
      wdata_rep = st_wdata;
    end
    if (!mem_we) strb = 4'b0000;
  end

  // Load formatting: move the addressed lane to bit 0, then extend
  logic [31:0] shifted;
  logic [31:0] load_fmt;
  assign shifted = data_sram_rdata >> {off, 3'b000};
  always_comb begin
    load_fmt = shifted;
    if (is_byte) begin
      load_fmt = is_unsigned ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    end else if (is_half) begin
      load_fmt = is_unsigned ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
    end else begin
      load_fmt = data_sram_rdata;
    end
  end

  // State and latched copy of the completed request
  state_t      state_q, state_d;
  logic [31:0] result_q, result_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic        re_q, re_d;

  // DONE keeps answering only while the producer still shows the same request
  logic done_match;
  assign done_match = ({req_pc, req_addr, mem_we, mem_re} == {pc_q, addr_q, we_q, re_q});

  logic        sram_req;
  logic        dcache_ok;
  logic        excp_ale;
  logic [31:0] mem_result;

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    we_d       = we_q;
    re_d       = re_q;
    sram_req   = 1'b0;
    dcache_ok  = 1'b0;
    excp_ale   = 1'b0;
    mem_result = 32'b0;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && done_match) begin
          dcache_ok  = 1'b1;
          mem_result = result_q;
        end else if (!access) begin
          dcache_ok = 1'b1;
          state_d   = IDLE;
        end else if (ale) begin
          dcache_ok = 1'b1;
          excp_ale  = 1'b1;
          state_d   = IDLE;
        end else begin
          // DONE with a changed bus is treated as IDLE in the same cycle
          sram_req = 1'b1;
          state_d  = data_sram_addr_ok ? WAIT : REQ;
        end
      end
      REQ: begin
        sram_req = 1'b1;
        if (data_sram_addr_ok) state_d = WAIT;
      end
      WAIT: begin
        if (data_sram_data_ok) begin
          result_d = mem_we ? 32'b0 : load_fmt;
          pc_d     = req_pc;
          addr_d   = req_addr;
          we_d     = mem_we;
          re_d     = mem_re;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= 32'b0;
      pc_q     <= 32'b0;
      addr_q   <= 32'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      re_q     <= re_d;
    end
  end

  // The memory shares our reset, so suppressing req during reset is enough
  assign data_sram_req   = sram_req && !reset;
  assign data_sram_wr    = mem_we;
  assign data_sram_wstrb = strb;
  assign data_sram_addr  = aligned_addr;
  assign data_sram_wdata = wdata_rep;
  assign ms_to_es_bus    = {excp_ale, dcache_ok, mem_result};

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic [102:0] es_to_ms_bus;
  logic [33:0]  ms_to_es_bus;
  logic         data_sram_req;
  logic         data_sram_wr;
  logic [3:0]   data_sram_wstrb;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         data_sram_addr_ok;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;

  mem_access_unit dut (
    .clk               (clk),
    .reset             (reset),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_es_bus      (ms_to_es_bus),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  always #5 clk = ~clk;

  logic        excp_ale, dcache_ok;
  logic [31:0] mem_result;
  assign {excp_ale, dcache_ok, mem_result} = ms_to_es_bus;

  int n_chk  = 0;
  int n_fail = 0;

  // One access: inputs, memory timing and expected outputs
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  bw;
    logic        we;
    logic        uns;
    logic [31:0] wd;
    logic [31:0] rd;
    int          ao;    // cycles addr_ok is withheld
    int          dd;    // cycles from acceptance to data_ok (>=1)
    int          hold;  // extra cycles the producer keeps the bus in DONE
    logic [3:0]  strb;
    logic [31:0] swd;
    logic [31:0] saddr;
    logic [31:0] res;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [102:0] pack(input logic [31:0] addr, input logic uns, input logic we,
                                        input logic re, input logic [3:0] bw,
                                        input logic [31:0] wd, input logic [31:0] pc);
    return {addr, uns, we, re, bw, wd, pc};
  endfunction

  // Reference model: derive the expected memory-side and result values
  // directly from the access-size rules with plain arithmetic.
  function automatic vec_t model(input logic [31:0] addr, input logic [3:0] bw, input logic we,
                                 input logic uns, input logic [31:0] wd, input logic [31:0] rd);
    vec_t v;
    logic [31:0] size, a, val, res;
    int off;
    v.addr = addr; v.bw = bw; v.we = we; v.uns = uns; v.wd = wd; v.rd = rd;
    v.ao = 0; v.dd = 1; v.hold = 0;
    size = (bw == 4'b0001) ? 32'd1 : (bw == 4'b0011) ? 32'd2 : 32'd4;
    a    = addr - (addr % size);
    off  = int'(a % 32'd4);
    v.saddr = a;
    if (!we)              v.strb = 4'h0;
    else if (size == 1)   v.strb = 4'(1 << off);
    else if (size == 2)   v.strb = 4'(3 << off);
    else                  v.strb = 4'hF;
    if (size == 1)        v.swd = 32'(wd[7:0]) * 32'h01010101;
    else if (size == 2)   v.swd = 32'(wd[15:0]) * 32'h00010001;
    else                  v.swd = wd;
    val = rd >> (8 * off);
    if (we) res = 32'h0;
    else if (size == 1) begin
      res = val & 32'hFF;
      if (!uns && res >= 32'h80) res = res + 32'hFFFFFF00;
    end else if (size == 2) begin
      res = val & 32'hFFFF;
      if (!uns && res >= 32'h8000) res = res + 32'hFFFF0000;
    end else res = rd;
    v.res = res;
    return v;
  endfunction

  // Issue one access and follow it to completion with the given memory timing
  task automatic run_txn(input vec_t v, input logic [31:0] pc, input string nm);
    es_to_ms_bus = pack(v.addr, v.uns, v.we, !v.we, v.bw, v.wd, pc);
    for (int c = 0; c <= v.ao; c++) begin
      data_sram_addr_ok = (c == v.ao);
      data_sram_data_ok = (c < v.ao) ? 1'($urandom_range(0, 1)) : 1'b0;
      data_sram_rdata   = $urandom;
      #3;
      chk({nm, " req"},   32'(data_sram_req), 32'd1);
      chk({nm, " addr"},  data_sram_addr, v.saddr);
      chk({nm, " wr"},    32'(data_sram_wr), 32'(v.we));
      chk({nm, " wstrb"}, 32'(data_sram_wstrb), 32'(v.strb));
      chk({nm, " wdata"}, data_sram_wdata, v.swd);
      chk({nm, " busy"},  32'(dcache_ok), 32'd0);
      chk({nm, " ale"},   32'(excp_ale), 32'd0);
      tick();
    end
    data_sram_addr_ok = 1'b0;
    for (int c = 1; c <= v.dd; c++) begin
      data_sram_data_ok = (c == v.dd);
      data_sram_rdata   = (c == v.dd) ? v.rd : $urandom;
      #3;
      chk({nm, " wait req"},  32'(data_sram_req), 32'd0);
      chk({nm, " wait busy"}, 32'(dcache_ok), 32'd0);
      tick();
    end
    data_sram_data_ok = 1'b0;
    for (int c = 0; c <= v.hold; c++) begin
      if (c > 0) begin
        data_sram_data_ok = 1'($urandom_range(0, 1));
        data_sram_rdata   = $urandom;
      end
      #3;
      chk({nm, " done ok"},  32'(dcache_ok), 32'd1);
      chk({nm, " result"},   mem_result, v.res);
      chk({nm, " done req"}, 32'(data_sram_req), 32'd0);
      chk({nm, " done ale"}, 32'(excp_ale), 32'd0);
      tick();
    end
    data_sram_data_ok = 1'b0;
  endtask

  // A cycle that must complete combinationally without a memory request
  task automatic run_noacc(input logic [102:0] bus, input logic exp_ale, input string nm);
    es_to_ms_bus      = bus;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    #3;
    chk({nm, " ok"},     32'(dcache_ok), 32'd1);
    chk({nm, " ale"},    32'(excp_ale), 32'(exp_ale));
    chk({nm, " result"}, mem_result, 32'd0);
    chk({nm, " req"},    32'(data_sram_req), 32'd0);
    tick();
  endtask

  vec_t tbl[10];

  initial begin
    // addr, bw, we, uns, wd, rd, ao, dd, hold, strb, swd, saddr, res
    tbl[0] = '{32'h1003, 4'b0001, 1'b0, 1'b0, 32'h0, 32'h80AABBCC, 0, 1, 0, 4'h0, 32'h0, 32'h1003, 32'hFFFFFF80};
    tbl[1] = '{32'h2002, 4'b0011, 1'b1, 1'b0, 32'h1234ABCD, 32'h0, 0, 1, 0, 4'b1100, 32'hABCDABCD, 32'h2002, 32'h0};
    tbl[2] = '{32'h4000, 4'b1111, 1'b0, 1'b0, 32'h11112222, 32'hDEADBEEF, 3, 1, 0, 4'h0, 32'h11112222, 32'h4000, 32'hDEADBEEF};
    tbl[3] = '{32'h5008, 4'b1111, 1'b0, 1'b0, 32'h0, 32'h01234567, 0, 2, 2, 4'h0, 32'h0, 32'h5008, 32'h01234567};
    tbl[4] = '{32'h500A, 4'b0011, 1'b0, 1'b1, 32'h0, 32'h89AB7654, 0, 1, 1, 4'h0, 32'h0, 32'h500A, 32'h000089AB};
    tbl[5] = '{32'h6000, 4'b0011, 1'b0, 1'b0, 32'h0, 32'h1234F00D, 1, 3, 0, 4'h0, 32'h0, 32'h6000, 32'hFFFFF00D};
    tbl[6] = '{32'h7001, 4'b0001, 1'b1, 1'b0, 32'h000000A5, 32'h0, 2, 1, 0, 4'b0010, 32'hA5A5A5A5, 32'h7001, 32'h0};
    tbl[7] = '{32'h7002, 4'b0001, 1'b0, 1'b1, 32'h0, 32'h00FE0000, 0, 1, 0, 4'h0, 32'h0, 32'h7002, 32'h000000FE};
    tbl[8] = '{32'h8004, 4'b0111, 1'b1, 1'b0, 32'hCAFEF00D, 32'h0, 0, 1, 0, 4'hF, 32'hCAFEF00D, 32'h8004, 32'h0};
    tbl[9] = '{32'h9000, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h7FFF8000, 1, 1, 1, 4'h0, 32'h0, 32'h9000, 32'h7FFF8000};

    reset             = 1'b1;
    es_to_ms_bus      = pack(32'h40, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h0);
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    #3;
    chk("reset req gated", 32'(data_sram_req), 32'd0);
    tick();
    reset = 1'b0;
    run_noacc('0, 1'b0, "post-reset idle");

    // Table vectors, back to back: each new access appears in the DONE cycle switch
    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i], 32'h100 + 32'(i) * 4, $sformatf("vec%0d", i));
    end

    // No access straight out of DONE must not leak the captured result
    run_noacc(pack(32'h1234, 1'b0, 1'b0, 1'b0, 4'b1111, 32'hFFFF, 32'h200), 1'b0, "noacc after done");

    // Misaligned word load
`ifdef DMEM_ALE_CHECK_EN
    run_noacc(pack(32'h3001, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h300), 1'b1, "ale word");
`else
    run_txn(model(32'h3001, 4'b1111, 1'b0, 1'b0, 32'h0, 32'h55667788), 32'h300, "misaligned word");
`endif

    // Reset while waiting for data: access is abandoned, FSM back in IDLE
    es_to_ms_bus      = pack(32'hA000, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h400);
    data_sram_addr_ok = 1'b1;
    #3;
    chk("rst seq req", 32'(data_sram_req), 32'd1);
    tick();
    data_sram_addr_ok = 1'b0;
    reset             = 1'b1;
    #3;
    chk("rst in wait req", 32'(data_sram_req), 32'd0);
    tick();
    reset = 1'b0;
    run_noacc('0, 1'b0, "after mid reset");
    run_txn(model(32'hA000, 4'b1111, 1'b0, 1'b0, 32'h0, 32'h0BADCAFE), 32'h404, "reissue after reset");

    // Randomized accesses against the reference model
    for (int k = 0; k < 60; k++) begin
      logic [31:0] addr;
      logic [3:0]  bw;
      logic        we, uns;
      vec_t        v;
      int          kind;
      kind = $urandom_range(0, 9);
      addr = $urandom;
      case ($urandom_range(0, 3))
        0: bw = 4'b0001;
        1: bw = 4'b0011;
        2: bw = 4'b1111;
        default: bw = 4'($urandom);
      endcase
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      if (kind == 0) begin
        run_noacc(pack(addr, uns, 1'b0, 1'b0, bw, $urandom, 32'h10000 + 32'(k) * 4), 1'b0, "rand noacc");
      end else begin
        v      = model(addr, bw, we, uns, $urandom, $urandom);
        v.ao   = $urandom_range(0, 3);
        v.dd   = $urandom_range(1, 3);
        v.hold = $urandom_range(0, 2);
`ifdef DMEM_ALE_CHECK_EN
        if (v.saddr != addr)
          run_noacc(pack(addr, uns, we, !we, bw, v.wd, 32'h10000 + 32'(k) * 4), 1'b1, "rand ale");
        else
          run_txn(v, 32'h10000 + 32'(k) * 4, "rand");
`else
        run_txn(v, 32'h10000 + 32'(k) * 4, "rand");
`endif
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
